// File: rtl/mem_port_arbiter.sv
// Shares one external SRAM port between fetch and data access; data has fixed priority.
// Optional port timeout with DEADBEEF/bus_err completion is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        port_en,
  output logic [3:0]  port_we,
  output logic [31:0] port_addr,
  output logic [31:0] port_wdata,
  input  logic [31:0] port_rdata,
  input  logic        port_ready,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_err
);

  // state     | meaning
  // IDLE      | port free, sampling requests (data before fetch)
  // DATA_BUSY | port owned by data access, waiting for port_ready
  // INST_BUSY | port owned by fetch, waiting for port_ready
  // RESP      | one-cycle done pulse to the owner, requests ignored
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_BUSY = 2'd1,
    INST_BUSY = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        own_data, own_data_nx;
  logic        drop, drop_nx;
  logic        port_en_nx;
  logic [3:0]  port_we_nx;
  logic [31:0] port_addr_nx, port_wdata_nx;
  logic [31:0] if_rdata_nx, mem_rdata_nx;
  logic        busy, drop_now, xfer_end;
  logic [31:0] resp_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt, to_cnt_nx;
  logic             err, err_nx, timed_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      own_data   <= 1'b0;
      drop       <= 1'b0;
      port_en    <= 1'b0;
      port_we    <= 4'h0;
      port_addr  <= 32'h0;
      port_wdata <= 32'h0;
      if_rdata   <= 32'h0;
      mem_rdata  <= 32'h0;
    end else begin
      state      <= state_nx;
      own_data   <= own_data_nx;
      drop       <= drop_nx;
      port_en    <= port_en_nx;
      port_we    <= port_we_nx;
      port_addr  <= port_addr_nx;
      port_wdata <= port_wdata_nx;
      if_rdata   <= if_rdata_nx;
      mem_rdata  <= mem_rdata_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nx;
      err    <= err_nx;
    end
  end
`endif

  always_comb begin
    state_nx      = state;
    own_data_nx   = own_data;
    drop_nx       = drop;
    port_en_nx    = port_en;
    port_we_nx    = port_we;
    port_addr_nx  = port_addr;
    port_wdata_nx = port_wdata;
    if_rdata_nx   = if_rdata;
    mem_rdata_nx  = mem_rdata;
    busy          = (state == DATA_BUSY) || (state == INST_BUSY);
    // a flush landing on the completing edge still drops the fetch
    drop_now      = drop | ((state == INST_BUSY) & flush);
    xfer_end      = busy & port_ready;
    resp_data     = port_rdata;
`ifdef ARB_TIMEOUT_EN
    to_cnt_nx     = to_cnt;
    err_nx        = err;
    timed_out     = busy & ~port_ready & (to_cnt == TO_LAST);
    xfer_end      = busy & (port_ready | timed_out);
    if (timed_out) resp_data = 32'hDEADBEEF;
`endif

    case (state)
      IDLE: begin
        if (mem_req) begin
          state_nx      = DATA_BUSY;
          own_data_nx   = 1'b1;
          port_en_nx    = 1'b1;
          port_we_nx    = mem_we;
          port_addr_nx  = mem_addr;
          port_wdata_nx = mem_wdata;
        end else if (if_req && !flush) begin
          state_nx      = INST_BUSY;
          own_data_nx   = 1'b0;
          port_en_nx    = 1'b1;
          port_we_nx    = 4'h0;
          port_addr_nx  = if_addr;
          port_wdata_nx = 32'h0;
        end
`ifdef ARB_TIMEOUT_EN
        to_cnt_nx = '0;
`endif
      end
      DATA_BUSY, INST_BUSY: begin
        drop_nx = drop_now;
        if (xfer_end) begin
          if (own_data) mem_rdata_nx = resp_data;
          else if (!drop_now) if_rdata_nx = resp_data;
          port_en_nx    = 1'b0;
          port_we_nx    = 4'h0;
          port_addr_nx  = 32'h0;
          port_wdata_nx = 32'h0;
          state_nx      = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        err_nx = timed_out;
        if (!port_ready && !timed_out) to_cnt_nx = to_cnt + CNT_W'(1);
`endif
      end
      RESP: begin
        state_nx = IDLE;
        drop_nx  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_nx   = 1'b0;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_done     = (state == RESP) & own_data;
  assign if_done      = (state == RESP) & ~own_data & ~drop;
  assign stallreq_mem = mem_req & ~mem_done;
  assign stallreq_if  = if_req & ~if_done & ~flush;

`ifdef ARB_TIMEOUT_EN
  assign bus_err = err & (mem_done | if_done);
`else
  assign bus_err = 1'b0;
`endif

endmodule
